// File: rtl/fifo_depth8_fwft_pkg.sv
// Shared constants and types for the 8-entry FWFT FIFO and its read mux.
package fifo_depth8_fwft_pkg;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned PTR_W      = 4;  // [2:0] index, [3] wrap
  localparam int unsigned IDX_W      = 3;

  // Sticky error flags, one bit per error class.
  typedef struct packed {
    logic ovf;  // write attempted while full
    logic udf;  // read attempted while empty
  } err_flags_t;

  localparam err_flags_t ERR_NONE = '{ovf: 1'b0, udf: 1'b0};

  // Word width of a SIMD-packed word.
  function automatic int unsigned word_w(input int unsigned bw, input int unsigned simd);
    return bw * simd;
  endfunction

endpackage

// File: rtl/fifo_depth8_fwft_if.sv
// Producer/consumer-facing bus of the FWFT FIFO.
//   master: drives in/wr/rd/clr, observes out and status flags
//   slave : the FIFO itself
interface fifo_depth8_fwft_if #(
  parameter int unsigned W = 4
);
  import fifo_depth8_fwft_pkg::*;

  logic             clr;
  logic [W-1:0]     in;
  logic             wr;
  logic             rd;
  logic [W-1:0]     out;
  logic             o_full;
  logic             o_empty;
  logic [PTR_W-1:0] o_count;
  logic             o_ovf;
  logic             o_udf;

  modport master (
    output clr, in, wr, rd,
    input  out, o_full, o_empty, o_count, o_ovf, o_udf
  );

  modport slave (
    input  clr, in, wr, rd,
    output out, o_full, o_empty, o_count, o_ovf, o_udf
  );

endinterface

// File: rtl/fifo_mux_8_1.sv
// 8:1 read-data selector for the FIFO storage.
//   sel      : entry index (read pointer index bits)
//   in0..in7 : storage entries
//   out      : selected entry
module fifo_mux_8_1
  import fifo_depth8_fwft_pkg::*;
#(
  parameter int unsigned bw   = 4,
  parameter int unsigned simd = 1
) (
  input  logic [IDX_W-1:0]             sel,
  input  logic [word_w(bw, simd)-1:0]  in0,
  input  logic [word_w(bw, simd)-1:0]  in1,
  input  logic [word_w(bw, simd)-1:0]  in2,
  input  logic [word_w(bw, simd)-1:0]  in3,
  input  logic [word_w(bw, simd)-1:0]  in4,
  input  logic [word_w(bw, simd)-1:0]  in5,
  input  logic [word_w(bw, simd)-1:0]  in6,
  input  logic [word_w(bw, simd)-1:0]  in7,
  output logic [word_w(bw, simd)-1:0]  out
);

  // Pure combinational select.
  always_comb begin
    out = in0;
    case (sel)
      3'd0: out = in0;
      3'd1: out = in1;
      3'd2: out = in2;
      3'd3: out = in3;
      3'd4: out = in4;
      3'd5: out = in5;
      3'd6: out = in6;
      3'd7: out = in7;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/fifo_depth8_fwft.sv
// Eight-entry single-clock first-word-fall-through FIFO.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of fifo_depth8_fwft_if
//           clr (sync flush), in/wr (write), rd (pop),
//           out (head, valid when o_empty=0), o_full, o_empty,
//           o_count (0..8), o_ovf/o_udf (sticky errors)
module fifo_depth8_fwft
  import fifo_depth8_fwft_pkg::*;
#(
  parameter int unsigned bw   = 4,
  parameter int unsigned simd = 1
) (
  input  logic                clk,
  input  logic                reset,
  fifo_depth8_fwft_if.slave   bus
);

  localparam int unsigned W = word_w(bw, simd);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  err_flags_t       err;
  logic [W-1:0]     q [FIFO_DEPTH];

  logic full_c;
  logic empty_c;
  logic wr_en_c;
  logic rd_en_c;

  // Status derived from the registered pointers; wrap bit breaks the full/empty tie.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

  // Accepts use pre-edge state; a flush overrides both.
  assign wr_en_c = bus.wr && !full_c  && !bus.clr;
  assign rd_en_c = bus.rd && !empty_c && !bus.clr;

  assign bus.o_empty = empty_c;
  assign bus.o_full  = full_c;
  assign bus.o_count = wr_ptr - rd_ptr;
  assign bus.o_ovf   = err.ovf;
  assign bus.o_udf   = err.udf;

  // Pointer and sticky-error state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      err    <= ERR_NONE;
    end else if (bus.clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      err    <= ERR_NONE;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en_c) rd_ptr <= rd_ptr + PTR_W'(1);
      err.ovf <= err.ovf | (bus.wr && full_c);
      err.udf <= err.udf | (bus.rd && empty_c);
    end
  end

  // Data storage; intentionally unreset since contents are only read once written.
  always_ff @(posedge clk) begin
    if (wr_en_c) q[wr_ptr[IDX_W-1:0]] <= bus.in;
  end

  fifo_mux_8_1 #(
    .bw   (bw),
    .simd (simd)
  ) u_rd_mux (
    .sel (rd_ptr[IDX_W-1:0]),
    .in0 (q[0]),
    .in1 (q[1]),
    .in2 (q[2]),
    .in3 (q[3]),
    .in4 (q[4]),
    .in5 (q[5]),
    .in6 (q[6]),
    .in7 (q[7]),
    .out (bus.out)
  );

endmodule

// File: tb/tb_fifo_depth8_fwft.sv
// Directed self-checking bench for fifo_depth8_fwft (bw=4, simd=1).
module tb_fifo_depth8_fwft;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_depth8_fwft_if #(.W(4)) bus ();

  fifo_depth8_fwft #(.bw(4), .simd(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
  endtask

  task automatic flush();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
  endtask

  task automatic push(input logic [3:0] v);
    bus.in = v;
    bus.wr = 1'b1;
    step();
    bus.wr = 1'b0;
  endtask

  logic [3:0] model_q[$];
  logic [3:0] v;

  initial begin
    reset   = 1'b0;
    bus.in  = 4'h0;
    idle();

    // Reset state
    #3;
    check("rst_empty", 32'(bus.o_empty), 32'd1);
    check("rst_full",  32'(bus.o_full),  32'd0);
    check("rst_count", 32'(bus.o_count), 32'd0);
    check("rst_ovf",   32'(bus.o_ovf),   32'd0);
    check("rst_udf",   32'(bus.o_udf),   32'd0);
    @(posedge clk);
    #2 reset = 1'b1;

    // Fill 1..8: head stays 1, count climbs, full on the 8th
    for (int i = 1; i <= 8; i++) begin
      push(4'(i));
      check("fill_count", 32'(bus.o_count), 32'(i));
      check("fill_head",  32'(bus.out),     32'd1);
      check("fill_full",  32'(bus.o_full),  32'(i == 8));
    end

    // Drain 8 in order
    for (int i = 1; i <= 8; i++) begin
      check("drain_head", 32'(bus.out), 32'(i));
      bus.rd = 1'b1;
      step();
      bus.rd = 1'b0;
      check("drain_count", 32'(bus.o_count), 32'(8 - i));
    end
    check("drain_empty", 32'(bus.o_empty), 32'd1);
    check("drain_udf",   32'(bus.o_udf),   32'd0);
    check("drain_ovf",   32'(bus.o_ovf),   32'd0);

    // Full with simultaneous wr/rd: pop succeeds, write dropped, ovf sticky
    for (int i = 1; i <= 8; i++) push(4'(i));
    check("full2", 32'(bus.o_full), 32'd1);
    bus.in = 4'h9;
    bus.wr = 1'b1;
    bus.rd = 1'b1;
    step();
    idle();
    check("fullrw_count", 32'(bus.o_count), 32'd7);
    check("fullrw_ovf",   32'(bus.o_ovf),   32'd1);
    check("fullrw_head",  32'(bus.out),     32'd2);
    flush();
    check("clr_count", 32'(bus.o_count), 32'd0);
    check("clr_empty", 32'(bus.o_empty), 32'd1);
    check("clr_ovf",   32'(bus.o_ovf),   32'd0);

    // Empty with simultaneous wr/rd: write taken, read rejected
    bus.in = 4'h5;
    bus.wr = 1'b1;
    bus.rd = 1'b1;
    step();
    idle();
    check("emptyrw_count", 32'(bus.o_count), 32'd1);
    check("emptyrw_head",  32'(bus.out),     32'd5);
    check("emptyrw_udf",   32'(bus.o_udf),   32'd1);

    // clr beats a same-cycle write
    bus.in  = 4'h7;
    bus.wr  = 1'b1;
    bus.clr = 1'b1;
    step();
    idle();
    check("clrwr_count", 32'(bus.o_count), 32'd0);
    check("clrwr_udf",   32'(bus.o_udf),   32'd0);

    // Steady stream over multiple wraps
    model_q.delete();
    for (int i = 1; i <= 3; i++) begin
      push(4'(i));
      model_q.push_back(4'(i));
    end
    for (int k = 0; k < 20; k++) begin
      v = 4'(k + 4);
      check("stream_head", 32'(bus.out), 32'(model_q[0]));
      bus.in = v;
      bus.wr = 1'b1;
      bus.rd = 1'b1;
      step();
      void'(model_q.pop_front());
      model_q.push_back(v);
      check("stream_count", 32'(bus.o_count), 32'd3);
    end
    idle();
    check("stream_full", 32'(bus.o_full), 32'd0);
    check("stream_ovf",  32'(bus.o_ovf),  32'd0);
    check("stream_udf",  32'(bus.o_udf),  32'd0);
    for (int i = 0; i < 3; i++) begin
      check("stream_tail", 32'(bus.out), 32'(model_q[i]));
      bus.rd = 1'b1;
      step();
      bus.rd = 1'b0;
    end
    check("stream_empty", 32'(bus.o_empty), 32'd1);

    // Async reset mid-cycle with 5 words held
    flush();
    for (int i = 1; i <= 5; i++) push(4'(i + 10));
    check("pre_rst_count", 32'(bus.o_count), 32'd5);
    #2 reset = 1'b0;
    #1;
    check("async_empty", 32'(bus.o_empty), 32'd1);
    check("async_count", 32'(bus.o_count), 32'd0);
    check("async_full",  32'(bus.o_full),  32'd0);
    #1 reset = 1'b1;
    check("release_empty", 32'(bus.o_empty), 32'd1);
    push(4'hA);
    check("post_rst_head",  32'(bus.out),     32'hA);
    check("post_rst_count", 32'(bus.o_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
